sm83_fetch_unit: RTL and testbench
==================================

# sm83_fetch_unit

Instruction/immediate fetch sequencer for the SM83 core, sitting directly upstream of the register file. On a request from the control sequencer it reads one or two bytes from the memory bus starting at the current PC, then produces single-cycle write strobes for IR and PC (and an immediate operand) that connect straight to the register file's `wen.ir`/`w_ir` and `wen.pc`/`w_pc` inputs. It handles the 0xCB prefix byte internally so that control sees a single fetch.

## Interface
No parameters.
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin a fetch; accepted only when `busy`=0 and `done`=0
- mode  in  2  fetch kind: 0 opcode, 1 imm8, 2 imm16, 3 reserved (start ignored)
- pc_in  in  16  current PC (register file `r_pc`)
- flush  in  1  synchronous abort of any fetch in progress
- halt_bug  in  1  suppress first PC increment (effective only with macro)
- mem_req  out  1  bus read request
- mem_addr  out  16  bus read address
- mem_ack  in  1  read data valid this cycle
- mem_rdata  in  8  read data
- ir_wen  out  1  IR write strobe
- ir_data  out  8  opcode to IR
- pc_wen  out  1  PC write strobe
- pc_data  out  16  next PC
- imm  out  16  immediate operand, zero-extended for imm8
- cb_prefix  out  1  last opcode was CB-prefixed
- busy  out  1  fetch in progress
- done  out  1  fetch complete pulse

## Operation
- States: IDLE, BYTE0, BYTE1. All outputs are registered.
- IDLE: on accepted start, latch `addr` = `pc_in` and `mode`; go to BYTE0. `busy`=1 from the next cycle.
- BYTE0: `mem_req`=1, `mem_addr`=`addr`. Hold until `mem_ack`. On ack:
  - opcode, data≠0xCB: finish with ir_data=data, pc_data=addr+1, cb_prefix←0.
  - opcode, data=0xCB: go to BYTE1 at addr+1. No writes.
  - imm8: finish with imm={8'h00,data}, pc_data=addr+1.
  - imm16: imm[7:0]=data; go to BYTE1 at addr+1.
- BYTE1: `mem_req`=1, `mem_addr`=addr+1. On ack:
  - CB case: finish with ir_data=data, cb_prefix←1, pc_data=addr+2.
  - imm16: imm[15:8]=data, pc_data=addr+2.
- Finish: return to IDLE. The next cycle pulses `done`=1 and `pc_wen`=1 for exactly one cycle. `ir_wen`=1 only for opcode mode.
- A start is ignored while `done` is high, because the register file PC is stale that cycle.
- All PC arithmetic is 16-bit and wraps: 0xFFFF+1=0x0000, 0xFFFF+2=0x0001.
- `cb_prefix` is sticky. It changes only when an opcode fetch finishes. `imm` holds its value until overwritten.
- `mem_ack` is ignored while `mem_req`=0.
- flush: from any state, the FSM goes to IDLE on the next edge. `mem_req` drops, and no `ir_wen`, `pc_wen` or `done` is produced. If flush and start arrive in the same cycle, flush wins. If flush arrives in the cycle after the final ack, the already-scheduled strobes are suppressed.
- Reset: all outputs are 0, `imm`=0, state is IDLE.

## Timing
- `mem_req` and `mem_addr` are valid the cycle after start and stay stable until ack.
- Zero-wait bus (ack in the first request cycle):
  - 1-byte fetch: `done` 2 cycles after start.
  - 2-byte fetch (CB or imm16): `done` 3 cycles after start.
- Each bus wait cycle adds one cycle.
- The register file captures IR/PC at the end of the `done` cycle. A start is accepted earliest in the cycle after `done`.

## Configuration
- SM83_HALT_BUG_EN defined:
  - If `halt_bug`=1 when an opcode-mode start is accepted, the first byte does not advance PC.
  - Non-CB opcode: pc_data=addr.
  - CB opcode: the second byte is read from addr (again), and pc_data=addr+1.
  - `halt_bug` is ignored in imm modes.
- Undefined: the `halt_bug` input is ignored and all fetches increment normally.

## Test plan
- pc_in=0x0100, opcode, mem_rdata=0x3E, zero-wait -> ir_wen and pc_wen pulse together with done 2 cycles after start; ir_data=0x3E, pc_data=0x0101, cb_prefix=0.
- pc_in=0x0200, opcode, bytes 0xCB then 0x37 with 2 wait cycles on byte1 -> mem_addr 0x0200 then 0x0201; ir_data=0x37, cb_prefix=1, pc_data=0x0202, done 5 cycles after start.
- pc_in=0xFFFF, imm16, bytes 0x34, 0x12 -> addresses 0xFFFF then 0x0000; imm=0x1234, pc_data=0x0001, ir_wen never asserted.
- flush asserted while waiting on byte0 ack -> mem_req drops next cycle, no ir_wen/pc_wen/done; a new start 1 cycle later fetches normally.
- start asserted during done, and mode=3 start -> both ignored, mem_req stays 0.
- With SM83_HALT_BUG_EN: halt_bug=1, pc_in=0x0150, opcode 0x00 -> pc_data=0x0150. Same stimulus without the macro -> pc_data=0x0151.

Source files
------------

// File: rtl/sm83_fetch_unit.sv
// SM83 opcode/immediate fetch sequencer: reads 1-2 bytes at PC and emits IR/PC/imm write strobes.
// Optional HALT-bug PC suppression is compiled in with SM83_HALT_BUG_EN.
module sm83_fetch_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic [15:0] pc_in,
  input  logic        flush,
  input  logic        halt_bug,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        ir_wen,
  output logic [7:0]  ir_data,
  output logic        pc_wen,
  output logic [15:0] pc_data,
  output logic [15:0] imm,
  output logic        cb_prefix,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BYTE0 = 2'd1,
    BYTE1 = 2'd2
  } state_e;

  localparam logic [1:0] MODE_OP    = 2'd0;
  localparam logic [1:0] MODE_IMM8  = 2'd1;
  localparam logic [1:0] MODE_IMM16 = 2'd2;
  localparam logic [1:0] MODE_RSVD  = 2'd3;
  localparam logic [7:0] CB_BYTE    = 8'hCB;

  state_e      state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic        hb_q, hb_d;
  logic [7:0]  ir_data_q, ir_data_d;
  logic [15:0] pc_data_q, pc_data_d;
  logic [15:0] imm_q, imm_d;
  logic        cb_q, cb_d;
  logic        done_q, done_d;
  logic        irw_q, irw_d;
  logic        accept;
  logic        hb_req;
  logic [15:0] step;

`ifdef SM83_HALT_BUG_EN
  assign hb_req = halt_bug && (mode == MODE_OP);
`else
  logic unused_halt_bug;
  assign unused_halt_bug = halt_bug;
  assign hb_req = 1'b0;
`endif

  // done_q blocks a new start: the register file has not yet captured the new PC.
  assign accept = start && !flush && !done_q && (state_q == IDLE) && (mode != MODE_RSVD);
  assign step   = hb_q ? 16'd0 : 16'd1;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    addr_d     = addr_q;
    mem_addr_d = mem_addr_q;
    hb_d       = hb_q;
    ir_data_d  = ir_data_q;
    pc_data_d  = pc_data_q;
    imm_d      = imm_q;
    cb_d       = cb_q;
    done_d     = 1'b0;
    irw_d      = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_d    = BYTE0;
            mode_d     = mode;
            addr_d     = pc_in;
            mem_addr_d = pc_in;
            hb_d       = hb_req;
          end
        end
        BYTE0: begin
          if (mem_ack) begin
            case (mode_q)
              MODE_OP: begin
                if (mem_rdata == CB_BYTE) begin
                  state_d    = BYTE1;
                  mem_addr_d = addr_q + step;
                end else begin
                  state_d   = IDLE;
                  ir_data_d = mem_rdata;
                  pc_data_d = addr_q + step;
                  cb_d      = 1'b0;
                  irw_d     = 1'b1;
                  done_d    = 1'b1;
                end
              end
              MODE_IMM8: begin
                state_d   = IDLE;
                imm_d     = {8'h00, mem_rdata};
                pc_data_d = addr_q + 16'd1;
                done_d    = 1'b1;
              end
              MODE_IMM16: begin
                state_d    = BYTE1;
                imm_d[7:0] = mem_rdata;
                mem_addr_d = addr_q + 16'd1;
              end
              default: state_d = IDLE;
            endcase
          end
        end
        BYTE1: begin
          if (mem_ack) begin
            state_d   = IDLE;
            pc_data_d = mem_addr_q + 16'd1;
            done_d    = 1'b1;
            if (mode_q == MODE_OP) begin
              ir_data_d = mem_rdata;
              cb_d      = 1'b1;
              irw_d     = 1'b1;
            end else begin
              imm_d[15:8] = mem_rdata;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mode_q     <= MODE_OP;
      addr_q     <= 16'h0000;
      mem_addr_q <= 16'h0000;
      hb_q       <= 1'b0;
      ir_data_q  <= 8'h00;
      pc_data_q  <= 16'h0000;
      imm_q      <= 16'h0000;
      cb_q       <= 1'b0;
      done_q     <= 1'b0;
      irw_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      addr_q     <= addr_d;
      mem_addr_q <= mem_addr_d;
      hb_q       <= hb_d;
      ir_data_q  <= ir_data_d;
      pc_data_q  <= pc_data_d;
      imm_q      <= imm_d;
      cb_q       <= cb_d;
      done_q     <= done_d;
      irw_q      <= irw_d;
    end
  end

  // A flush in the strobe cycle still has to cancel the register-file write.
  assign done      = done_q && !flush;
  assign pc_wen    = done_q && !flush;
  assign ir_wen    = irw_q && !flush;
  assign mem_req   = (state_q != IDLE);
  assign busy      = (state_q != IDLE);
  assign mem_addr  = mem_addr_q;
  assign ir_data   = ir_data_q;
  assign pc_data   = pc_data_q;
  assign imm       = imm_q;
  assign cb_prefix = cb_q;

endmodule

// File: tb/tb_sm83_fetch_unit.sv
// Scoreboard bench for sm83_fetch_unit: expected fetch results queued at start, checked at done.
module tb_sm83_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  mode;
  logic [15:0] pc_in;
  logic        flush;
  logic        halt_bug;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        ir_wen;
  logic [7:0]  ir_data;
  logic        pc_wen;
  logic [15:0] pc_data;
  logic [15:0] imm;
  logic        cb_prefix;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  sm83_fetch_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .pc_in     (pc_in),
    .flush     (flush),
    .halt_bug  (halt_bug),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .ir_wen    (ir_wen),
    .ir_data   (ir_data),
    .pc_wen    (pc_wen),
    .pc_data   (pc_data),
    .imm       (imm),
    .cb_prefix (cb_prefix),
    .busy      (busy),
    .done      (done)
  );

`ifdef SM83_HALT_BUG_EN
  localparam bit HB = 1'b1;
`else
  localparam bit HB = 1'b0;
`endif

  typedef struct {
    logic        ir_wen;
    logic [7:0]  ir;
    logic [15:0] pc;
    logic [15:0] imm;
    logic        cb;
    int          lat;
    int          t0;
  } exp_t;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  exp_t        sb[$];
  logic [15:0] exp_addr[$];
  int          waits[$];
  bit   [7:0]  mem [0:65535];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Bus model: per-request wait counts come from the waits queue (0 when empty).
  bit in_req = 1'b0;
  int wcnt   = 0;
  always @(negedge clk) begin : bus
    logic [31:0] ea;
    mem_ack = 1'b0;
    if (mem_req) begin
      if (!in_req) begin
        in_req = 1'b1;
        wcnt   = (waits.size() != 0) ? waits.pop_front() : 0;
      end
      if (wcnt == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr];
        ea = 32'hDEAD_BEEF;
        if (exp_addr.size() != 0) ea = 32'(exp_addr.pop_front());
        check_eq("mem_addr", 32'(mem_addr), ea);
        in_req = 1'b0;
      end else begin
        wcnt--;
      end
    end else begin
      in_req = 1'b0;
    end
  end

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      if ((ir_wen || pc_wen) && !done)
        check_eq("wen_without_done", 32'({ir_wen, pc_wen}), 32'd0);
      if (done) begin
        check_eq("done_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check_eq("pc_wen", 32'(pc_wen), 32'd1);
          check_eq("ir_wen", 32'(ir_wen), 32'(e.ir_wen));
          if (e.ir_wen) check_eq("ir_data", 32'(ir_data), 32'(e.ir));
          check_eq("pc_data", 32'(pc_data), 32'(e.pc));
          check_eq("imm", 32'(imm), 32'(e.imm));
          check_eq("cb_prefix", 32'(cb_prefix), 32'(e.cb));
          check_eq("latency", 32'(cyc - e.t0), 32'(e.lat));
        end
      end
    end
  end

  task automatic expect_fetch(input logic [15:0] pc, input int nb, input logic [15:0] a1,
                              input logic e_irw, input logic [7:0] e_ir, input logic [15:0] e_pc,
                              input logic [15:0] e_imm, input logic e_cb, input int e_lat);
    exp_t e;
    e.ir_wen = e_irw;
    e.ir     = e_ir;
    e.pc     = e_pc;
    e.imm    = e_imm;
    e.cb     = e_cb;
    e.lat    = e_lat;
    e.t0     = cyc;
    sb.push_back(e);
    exp_addr.push_back(pc);
    if (nb == 2) exp_addr.push_back(a1);
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after done.
  task automatic issue(input logic [1:0] m, input logic [15:0] pc, input logic hb,
                       input int nb, input logic [15:0] a1,
                       input logic e_irw, input logic [7:0] e_ir, input logic [15:0] e_pc,
                       input logic [15:0] e_imm, input logic e_cb, input int e_lat);
    expect_fetch(pc, nb, a1, e_irw, e_ir, e_pc, e_imm, e_cb, e_lat);
    start = 1'b1; mode = m; pc_in = pc; halt_bug = hb;
    @(negedge clk);
    check_eq("idle_at_start", 32'({busy, mem_req}), 32'd0);
    @(posedge clk); #1;
    start = 1'b0; halt_bug = 1'b0;
    @(negedge clk);
    check_eq("req_after_start", 32'({busy, mem_req}), 32'd3);
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    if (sb.size() != 0) begin
      check_eq("done_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
      exp_addr.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not terminate");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 2'd0; pc_in = 16'h0000;
    flush = 1'b0; halt_bug = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00;
    mem[16'h0100] = 8'h3E;
    mem[16'h0200] = 8'hCB; mem[16'h0201] = 8'h37;
    mem[16'hFFFF] = 8'h34; mem[16'h0000] = 8'h12;
    mem[16'h1234] = 8'hA5;
    mem[16'h8000] = 8'h00;
    mem[16'h3000] = 8'h99;
    mem[16'h4000] = 8'h76;
    mem[16'h5000] = 8'h11;
    mem[16'h6000] = 8'h22;
    mem[16'h0150] = 8'h00;
    mem[16'h0160] = 8'hCB; mem[16'h0161] = 8'h55;
    mem[16'h0170] = 8'h9A;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_mem_req", 32'(mem_req), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_wen", 32'({ir_wen, pc_wen}), 32'd0);
    check_eq("rst_imm", 32'(imm), 32'd0);
    check_eq("rst_cb", 32'(cb_prefix), 32'd0);
    check_eq("rst_pc_data", 32'(pc_data), 32'd0);
    check_eq("rst_ir_data", 32'(ir_data), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(2'd0, 16'h0100, 1'b0, 1, 16'h0000, 1'b1, 8'h3E, 16'h0101, 16'h0000, 1'b0, 2);
    waits = '{0, 2};
    issue(2'd0, 16'h0200, 1'b0, 2, 16'h0201, 1'b1, 8'h37, 16'h0202, 16'h0000, 1'b1, 5);
    issue(2'd2, 16'hFFFF, 1'b0, 2, 16'h0000, 1'b0, 8'h00, 16'h0001, 16'h1234, 1'b1, 3);
    waits = '{1};
    issue(2'd1, 16'h1234, 1'b0, 1, 16'h0000, 1'b0, 8'h00, 16'h1235, 16'h00A5, 1'b1, 3);
    issue(2'd0, 16'h8000, 1'b0, 1, 16'h0000, 1'b1, 8'h00, 16'h8001, 16'h00A5, 1'b0, 2);

    // Flush while byte0 is still waiting on the bus.
    waits = '{5};
    start = 1'b1; mode = 2'd0; pc_in = 16'h3000;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check_eq("wait_req", 32'({mem_req, mem_addr}), 32'({1'b1, 16'h3000}));
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    issue(2'd0, 16'h4000, 1'b0, 1, 16'h0000, 1'b1, 8'h76, 16'h4001, 16'h00A5, 1'b0, 2);

    // Flush in the strobe cycle cancels the scheduled writes.
    exp_addr.push_back(16'h5000);
    start = 1'b1; mode = 2'd0; pc_in = 16'h5000;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    check_eq("flush_strobes", 32'({done, pc_wen, ir_wen}), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check_eq("flush_idle", 32'({busy, done}), 32'd0);
    @(posedge clk); #1;

    // Start during done is ignored.
    expect_fetch(16'h6000, 1, 16'h0000, 1'b1, 8'h22, 16'h6001, 16'h00A5, 1'b0, 2);
    start = 1'b1; mode = 2'd0; pc_in = 16'h6000;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; pc_in = 16'h7000;
    @(negedge clk);
    check_eq("done_window", 32'(done), 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check_eq("start_in_done_ignored", 32'({busy, mem_req}), 32'd0);
    @(negedge clk);
    check_eq("start_in_done_ignored2", 32'({busy, mem_req}), 32'd0);
    @(posedge clk); #1;

    // Reserved mode, and flush colliding with start.
    start = 1'b1; mode = 2'd3; pc_in = 16'h7000;
    @(posedge clk); #1;
    start = 1'b0; mode = 2'd0;
    @(negedge clk);
    check_eq("mode3_ignored", 32'({busy, mem_req}), 32'd0);
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check_eq("flush_beats_start", 32'({busy, mem_req}), 32'd0);
    @(posedge clk); #1;

    // HALT bug: only effective when the feature is compiled in.
    issue(2'd0, 16'h0150, 1'b1, 1, 16'h0000, 1'b1, 8'h00,
          HB ? 16'h0150 : 16'h0151, 16'h00A5, 1'b0, 2);
    issue(2'd0, 16'h0160, 1'b1, 2, HB ? 16'h0160 : 16'h0161, 1'b1, HB ? 8'hCB : 8'h55,
          HB ? 16'h0161 : 16'h0162, 16'h00A5, 1'b1, 3);
    issue(2'd1, 16'h0170, 1'b1, 1, 16'h0000, 1'b0, 8'h00, 16'h0171, 16'h009A, 1'b1, 2);

    repeat (3) @(posedge clk);
    check_eq("sb_drained", 32'(sb.size() + exp_addr.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
